// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - EX/MEM memory-request bundle between execute stage and memory-stage controller
interface mem_access_ctrl_if #(
    parameter int ADDR_W  = 17,
    parameter int ALUOP_W = 8
);
    logic               req;
    logic [ALUOP_W-1:0] aluop;
    logic [ADDR_W-1:0]  addr;
    logic [31:0]        wdata_mem;
    logic [4:0]         wd;
    logic               wreg;
    logic [31:0]        wdata;

    modport master (output req, aluop, addr, wdata_mem, wd, wreg, wdata);
    modport slave  (input  req, aluop, addr, wdata_mem, wd, wreg, wdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte-serial load/store controller (optional MEM_MISALIGN_CHK_EN alignment check)
module mem_access_ctrl #(
    parameter int ADDR_W  = 17,
    parameter int ALUOP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  req_if,
    input  logic [7:0]        ram_din_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    output logic              stall_req_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);

    localparam logic [ALUOP_W-1:0] OP_LB  = ALUOP_W'(8'b1110_0000);
    localparam logic [ALUOP_W-1:0] OP_LH  = ALUOP_W'(8'b1110_0001);
    localparam logic [ALUOP_W-1:0] OP_LW  = ALUOP_W'(8'b1110_0011);
    localparam logic [ALUOP_W-1:0] OP_LBU = ALUOP_W'(8'b1110_0100);
    localparam logic [ALUOP_W-1:0] OP_LHU = ALUOP_W'(8'b1110_0101);
    localparam logic [ALUOP_W-1:0] OP_SB  = ALUOP_W'(8'b1110_1000);
    localparam logic [ALUOP_W-1:0] OP_SH  = ALUOP_W'(8'b1110_1001);
    localparam logic [ALUOP_W-1:0] OP_SW  = ALUOP_W'(8'b1110_1011);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LAST, S_DONE} state_t;

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] byte_cnt(input logic [ALUOP_W-1:0] op);
        if ((op == OP_LW) || (op == OP_SW))
            return 3'd4;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            return 3'd2;
        else
            return 3'd1;
    endfunction

    function automatic logic [31:0] load_ext(input logic [ALUOP_W-1:0] op, input logic [31:0] b);
        if (op == OP_LB)
            return {{24{b[7]}}, b[7:0]};
        else if (op == OP_LBU)
            return {24'd0, b[7:0]};
        else if (op == OP_LH)
            return {{16{b[15]}}, b[15:0]};
        else if (op == OP_LHU)
            return {16'd0, b[15:0]};
        else
            return b;
    endfunction

`ifdef MEM_MISALIGN_CHK_EN
    function automatic logic misaligned(input logic [ALUOP_W-1:0] op, input logic [1:0] a);
        if ((op == OP_LW) || (op == OP_SW))
            return a != 2'd0;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            return a[0];
        else
            return 1'b0;
    endfunction
`endif

    state_t             state_q, state_d;
    logic [2:0]         k_q, k_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        sdata_q, sdata_d;
    logic [4:0]         wd_q, wd_d;
    logic               wreg_q, wreg_d;
    logic [31:0]        buf_q, buf_d;
`ifdef MEM_MISALIGN_CHK_EN
    logic               mis_q, mis_d;
`endif

    // Raw outputs before reset gating
    logic [ADDR_W-1:0]  ram_addr_c;
    logic [7:0]         ram_dout_c;
    logic               ram_wr_c;
    logic               stall_c;
    logic [4:0]         wd_c;
    logic               wreg_c;
    logic [31:0]        wdata_c;
    logic               misalign_c;

    logic               req_valid;
    logic [2:0]         n_q;
    logic [1:0]         bidx;

    // Aluops outside the load/store set never start an access
    assign req_valid = req_if.req && (is_load(req_if.aluop) || is_store(req_if.aluop));
    assign n_q       = byte_cnt(aluop_q);
    // Read data lags the address by one cycle, so it belongs to the previous byte slot
    assign bidx      = k_q[1:0] - 2'd1;

    // State and latched request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            aluop_q <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            buf_q   <= '0;
`ifdef MEM_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            aluop_q <= aluop_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            buf_q   <= buf_d;
`ifdef MEM_MISALIGN_CHK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Next-state, byte sequencing and output decode
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        aluop_d    = aluop_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        buf_d      = buf_q;
`ifdef MEM_MISALIGN_CHK_EN
        mis_d      = mis_q;
`endif
        ram_addr_c = '0;
        ram_dout_c = '0;
        ram_wr_c   = 1'b0;
        stall_c    = 1'b0;
        wd_c       = '0;
        wreg_c     = 1'b0;
        wdata_c    = '0;
        misalign_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    stall_c = 1'b1;
                    aluop_d = req_if.aluop;
                    addr_d  = req_if.addr;
                    sdata_d = req_if.wdata_mem;
                    wd_d    = req_if.wd;
                    wreg_d  = req_if.wreg;
                    buf_d   = '0;
                    k_d     = '0;
                    state_d = S_ACCESS;
`ifdef MEM_MISALIGN_CHK_EN
                    mis_d = misaligned(req_if.aluop, req_if.addr[1:0]);
                    if (mis_d)
                        state_d = S_DONE;
`endif
                end else begin
                    wd_c    = req_if.wd;
                    wreg_c  = req_if.wreg;
                    wdata_c = req_if.wdata;
                end
            end
            S_ACCESS: begin
                stall_c    = 1'b1;
                ram_addr_c = addr_q + ADDR_W'(k_q);
                if (is_store(aluop_q)) begin
                    ram_wr_c   = 1'b1;
                    ram_dout_c = sdata_q[{k_q[1:0], 3'b000} +: 8];
                end else if (k_q != 3'd0) begin
                    buf_d[{bidx, 3'b000} +: 8] = ram_din_i;
                end
                k_d = k_q + 3'd1;
                if (k_q == n_q - 3'd1)
                    state_d = is_store(aluop_q) ? S_DONE : S_LAST;
            end
            S_LAST: begin
                stall_c = 1'b1;
                buf_d[{bidx, 3'b000} +: 8] = ram_din_i;
                state_d = S_DONE;
            end
            S_DONE: begin
                wd_c = wd_q;
                if (is_load(aluop_q)) begin
                    wreg_c  = wreg_q;
                    wdata_c = load_ext(aluop_q, buf_q);
                end
`ifdef MEM_MISALIGN_CHK_EN
                if (mis_q) begin
                    wreg_c     = 1'b0;
                    wdata_c    = '0;
                    misalign_c = 1'b1;
                end
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset forces every output low at once, including the combinational passthrough
    assign ram_addr_o  = rst ? ram_addr_c : '0;
    assign ram_dout_o  = rst ? ram_dout_c : '0;
    assign ram_wr_o    = rst & ram_wr_c;
    assign stall_req_o = rst & stall_c;
    assign wd_o        = rst ? wd_c : '0;
    assign wreg_o      = rst & wreg_c;
    assign wdata_o     = rst ? wdata_c : '0;
`ifdef MEM_MISALIGN_CHK_EN
    assign misalign_o  = rst & misalign_c;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_c;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
    localparam int ADDR_W = 17;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .ALUOP_W(8)) req_if ();

    logic [7:0]        ram_din;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic              stall;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
`ifdef MEM_MISALIGN_CHK_EN
    logic              misalign;
`endif

    mem_access_ctrl #(.ADDR_W(ADDR_W), .ALUOP_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_if      (req_if),
        .ram_din_i   (ram_din),
        .ram_addr_o  (ram_addr),
        .ram_dout_o  (ram_dout),
        .ram_wr_o    (ram_wr),
        .stall_req_o (stall),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o)
`ifdef MEM_MISALIGN_CHK_EN
        ,
        .misalign_o  (misalign)
`endif
    );

    // Byte RAM with one-cycle read latency plus a bench-side preload port
    logic [7:0]        ram [0:(1<<ADDR_W)-1];
    int                wr_cnt = 0;
    logic              pl_we = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [7:0]        pl_data = '0;

    always @(posedge clk) begin
        if (pl_we)
            ram[pl_addr] <= pl_data;
        else if (ram_wr) begin
            ram[ram_addr] <= ram_dout;
            wr_cnt <= wr_cnt + 1;
        end
        ram_din <= ram[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(posedge clk); #1;
        pl_we   = 1'b0;
    endtask

    task automatic drive(input logic r, input logic [7:0] op, input logic [ADDR_W-1:0] a,
                         input logic [31:0] sd, input logic [4:0] wd, input logic wr,
                         input logic [31:0] wdat);
        req_if.req       = r;
        req_if.aluop     = op;
        req_if.addr      = a;
        req_if.wdata_mem = sd;
        req_if.wd        = wd;
        req_if.wreg      = wr;
        req_if.wdata     = wdat;
    endtask

    // Issue one request, follow it to DONE and check latency and writeback
    task automatic run_op(input string tag, input logic [7:0] op, input logic [ADDR_W-1:0] a,
                          input logic [31:0] sd, input logic [4:0] wd, input int exp_lat,
                          input logic exp_wreg, input logic [31:0] exp_wdata);
        int lat;
        @(posedge clk); #1;
        drive(1'b1, op, a, sd, wd, 1'b1, 32'h0);
        #1 check({tag, " req stall"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, '0, 32'h0, 5'd0, 1'b0, 32'h0);
        lat = 0;
        while (stall === 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " done stall"}, 32'(stall), 32'd0);
        check({tag, " done ram_wr"}, 32'(ram_wr), 32'd0);
        check({tag, " done wd"}, 32'(wd_o), 32'(wd));
        check({tag, " done wreg"}, 32'(wreg_o), 32'(exp_wreg));
        check({tag, " done wdata"}, wdata_o, exp_wdata);
        @(posedge clk); #1;
    endtask

    int w0;

    initial begin
        // Reset gates the passthrough and stall even with a live request
        drive(1'b1, OP_SW, 17'h00100, 32'h1234_5678, 5'd7, 1'b1, 32'h55);
        #3;
        check("rst stall", 32'(stall), 32'd0);
        check("rst wdata", wdata_o, 32'd0);
        check("rst wreg", 32'(wreg_o), 32'd0);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        drive(1'b0, 8'h00, '0, 32'h0, 5'd0, 1'b0, 32'h0);
        #19 rst = 1'b1;

        // Non-memory passthrough, including req with a non-load/store aluop
        @(posedge clk); #1;
        drive(1'b0, OP_ADD, 17'h00050, 32'h0, 5'd3, 1'b1, 32'h0000_002A);
        #1;
        check("pass wdata", wdata_o, 32'h2A);
        check("pass wd", 32'(wd_o), 32'd3);
        check("pass stall", 32'(stall), 32'd0);
        req_if.req = 1'b1;
        #1;
        check("nonmem req stall", 32'(stall), 32'd0);
        check("nonmem req wdata", wdata_o, 32'h2A);
        @(posedge clk); #1;
        check("nonmem stays idle", 32'(stall), 32'd0);
        check("nonmem ram_wr", 32'(ram_wr), 32'd0);
        req_if.req = 1'b0;

        // SW 0xDEADBEEF at 0x100
        w0 = wr_cnt;
        run_op("sw", OP_SW, 17'h00100, 32'hDEAD_BEEF, 5'd9, 4, 1'b0, 32'h0);
        check("sw wrcnt", 32'(wr_cnt - w0), 32'd4);
        check("sw b0", 32'(ram[17'h100]), 32'hEF);
        check("sw b1", 32'(ram[17'h101]), 32'hBE);
        check("sw b2", 32'(ram[17'h102]), 32'hAD);
        check("sw b3", 32'(ram[17'h103]), 32'hDE);

        // LW from preloaded 78 56 34 12
        poke(17'h200, 8'h78);
        poke(17'h201, 8'h56);
        poke(17'h202, 8'h34);
        poke(17'h203, 8'h12);
        w0 = wr_cnt;
        run_op("lw", OP_LW, 17'h00200, 32'h0, 5'd5, 5, 1'b1, 32'h1234_5678);
        check("lw wrcnt", 32'(wr_cnt - w0), 32'd0);

        // Byte and halfword extension
        poke(17'h010, 8'h80);
        run_op("lb", OP_LB, 17'h00010, 32'h0, 5'd6, 2, 1'b1, 32'hFFFF_FF80);
        run_op("lbu", OP_LBU, 17'h00010, 32'h0, 5'd6, 2, 1'b1, 32'h0000_0080);
        poke(17'h010, 8'h00);
        poke(17'h011, 8'h80);
        run_op("lh", OP_LH, 17'h00010, 32'h0, 5'd8, 3, 1'b1, 32'hFFFF_8000);
        run_op("lhu", OP_LHU, 17'h00010, 32'h0, 5'd8, 3, 1'b1, 32'h0000_8000);

        // SB writes only the low byte
        poke(17'h301, 8'h5A);
        run_op("sb", OP_SB, 17'h00300, 32'hAABB_CCDD, 5'd1, 1, 1'b0, 32'h0);
        check("sb b0", 32'(ram[17'h300]), 32'hDD);
        check("sb b1 untouched", 32'(ram[17'h301]), 32'h5A);

`ifdef MEM_MISALIGN_CHK_EN
        // Misaligned LW goes straight to DONE with no RAM cycle
        w0 = wr_cnt;
        @(posedge clk); #1;
        drive(1'b1, OP_LW, 17'h00003, 32'h0, 5'd4, 1'b1, 32'h0);
        #1 check("mis req stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, '0, 32'h0, 5'd0, 1'b0, 32'h0);
        check("mis done stall", 32'(stall), 32'd0);
        check("mis pulse", 32'(misalign), 32'd1);
        check("mis wreg", 32'(wreg_o), 32'd0);
        check("mis wdata", wdata_o, 32'd0);
        check("mis ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        check("mis pulse end", 32'(misalign), 32'd0);
        check("mis wrcnt", 32'(wr_cnt - w0), 32'd0);
`else
        // SW across the top of the address space wraps to 0
        run_op("swwrap", OP_SW, 17'h1FFFE, 32'h1122_3344, 5'd2, 4, 1'b0, 32'h0);
        check("wrap b0", 32'(ram[17'h1FFFE]), 32'h44);
        check("wrap b1", 32'(ram[17'h1FFFF]), 32'h33);
        check("wrap b2", 32'(ram[17'h00000]), 32'h22);
        check("wrap b3", 32'(ram[17'h00001]), 32'h11);
`endif

        // Reset during the second byte of an SW aborts the rest
        poke(17'h400, 8'hA5);
        poke(17'h401, 8'hA5);
        poke(17'h402, 8'hA5);
        poke(17'h403, 8'hA5);
        w0 = wr_cnt;
        @(posedge clk); #1;
        drive(1'b1, OP_SW, 17'h00400, 32'h0102_0304, 5'd3, 1'b1, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, '0, 32'h0, 5'd0, 1'b0, 32'h0);
        check("abort k0 wr", 32'(ram_wr), 32'd1);
        check("abort k0 dout", 32'(ram_dout), 32'h04);
        @(posedge clk); #1;
        check("abort k1 addr", 32'(ram_addr), 32'h401);
        rst = 1'b0;
        #1;
        check("abort ram_wr", 32'(ram_wr), 32'd0);
        check("abort stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort idle stall", 32'(stall), 32'd0);
        check("abort wrcnt", 32'(wr_cnt - w0), 32'd1);
        check("abort b0", 32'(ram[17'h400]), 32'h04);
        check("abort b1", 32'(ram[17'h401]), 32'hA5);
        check("abort b2", 32'(ram[17'h402]), 32'hA5);
        check("abort b3", 32'(ram[17'h403]), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
